// File: rtl/digit_host_master.sv
// -----------------------------------------------------------------------------
// digit_host_master
//
// Avalon-MM initiator that runs one job against the digit-recognition slave.
// On start it streams IN_WORDS words from a valid/ready source into the
// slave's auto-incrementing write port. It then idles for GAP_CYCLES so the
// slave's pointer wrap can complete. Next it reads OUT_WORDS results from the
// auto-incrementing read port and returns them on a valid/ready stream through
// a small result FIFO.
//
// Optional feature: define DIGIT_HOST_POLL_EN to add a POLL state. In that
// state the master reads the status register after the gap and waits until
// bit 0 is set before it starts the read phase.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   start, busy, done     job control (done is a one-cycle pulse)
//   in_valid/in_ready/in_data     input word stream (16 bit)
//   out_valid/out_ready/out_data  result word stream (16 bit)
//   m_chipselect, m_address, m_read, m_write, m_writedata, m_readdata
//                         Avalon-MM master. There is no waitrequest, and read
//                         latency is fixed at 1 cycle.
// -----------------------------------------------------------------------------
module digit_host_master #(
   parameter int         IN_WORDS   = 26,
   parameter int         OUT_WORDS  = 11,
   parameter logic [2:0] WR_ADDR    = 3'h2,
   parameter logic [2:0] RD_ADDR    = 3'h3,
   parameter logic [2:0] ST_ADDR    = 3'h1,
   parameter int         GAP_CYCLES = 4,
   parameter int         RF_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic        busy,
   output logic        done,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_data,
   output logic        m_chipselect,
   output logic [2:0]  m_address,
   output logic        m_read,
   output logic        m_write,
   output logic [15:0] m_writedata,
   input  logic [15:0] m_readdata
);

   localparam int MAX_WORDS = (IN_WORDS > OUT_WORDS) ? IN_WORDS : OUT_WORDS;
   localparam int CW        = $clog2(MAX_WORDS + 1);
   localparam int GW        = $clog2(GAP_CYCLES + 1);
   localparam int AW        = $clog2(RF_DEPTH);

   localparam logic [CW-1:0] IN_LAST  = CW'(IN_WORDS - 1);
   localparam logic [CW-1:0] OUT_LAST = CW'(OUT_WORDS - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
   localparam logic [AW:0]   RF_FULL  = (AW + 1)'(RF_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_GAP,
`ifdef DIGIT_HOST_POLL_EN
      S_POLL,
`endif
      S_READ,
      S_DRAIN
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [GW-1:0] gap_cnt, gap_nxt;
   logic          rd_issue;
   logic          rd_pend;      // a data read was issued last cycle

   // Result FIFO
   logic [15:0]   rf_mem [RF_DEPTH];
   logic [AW-1:0] rf_wr_ptr, rf_rd_ptr;
   logic [AW:0]   rf_count;
   logic [AW:0]   rf_occ;       // occupancy plus the read still in flight
   logic          rf_push, rf_pop;

   assign rf_push   = rd_pend;
   assign rf_pop    = out_valid & out_ready;
   assign rf_occ    = rf_count + {{AW{1'b0}}, rd_pend};
   assign out_valid = (rf_count != '0);
   // Gating the head word keeps out_data at zero while the FIFO is empty,
   // so the storage array itself does not need a reset.
   assign out_data  = out_valid ? rf_mem[rf_rd_ptr] : '0;

`ifdef DIGIT_HOST_POLL_EN
   logic poll_issue;
   logic poll_pend;             // a status read was issued last cycle
`else
   // The status address only matters when polling is compiled in.
   logic unused_st;
   assign unused_st = ^ST_ADDR;
`endif

   // NOTE: sequential state uses non-blocking assignments only. All flops
   // then sample pre-edge values, whatever order the blocks run in.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         cnt       <= '0;
         gap_cnt   <= '0;
         rd_pend   <= 1'b0;
         rf_wr_ptr <= '0;
         rf_rd_ptr <= '0;
         rf_count  <= '0;
`ifdef DIGIT_HOST_POLL_EN
         poll_pend <= 1'b0;
`endif
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         gap_cnt <= gap_nxt;
         rd_pend <= rd_issue;
`ifdef DIGIT_HOST_POLL_EN
         poll_pend <= poll_issue;
`endif
         if (rf_push) rf_wr_ptr <= rf_wr_ptr + 1'b1;
         if (rf_pop)  rf_rd_ptr <= rf_rd_ptr + 1'b1;
         case ({rf_push, rf_pop})
            2'b10:   rf_count <= rf_count + 1'b1;
            2'b01:   rf_count <= rf_count - 1'b1;
            default: rf_count <= rf_count;
         endcase
      end
   end

   // NOTE: the FIFO storage has no reset. Flushing the pointers and the count
   // is enough, because a stale entry can never be presented.
   always_ff @(posedge clk) begin
      if (rf_push) rf_mem[rf_wr_ptr] <= m_readdata;
   end

   // NOTE: every output of this block gets a default first, so no path
   // through the case statement can leave a latch behind.
   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      gap_nxt      = gap_cnt;
      rd_issue     = 1'b0;
      busy         = (state != S_IDLE);
      done         = 1'b0;
      in_ready     = 1'b0;
      m_chipselect = 1'b0;
      m_read       = 1'b0;
      m_write      = 1'b0;
      m_address    = '0;
      m_writedata  = '0;
`ifdef DIGIT_HOST_POLL_EN
      poll_issue   = 1'b0;
`endif

      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_WRITE;
               cnt_nxt   = '0;
            end
         end

         S_WRITE: begin
            // The write strobe follows in_valid directly, so a missing input
            // word simply stalls the phase.
            in_ready     = in_valid;
            m_write      = in_valid;
            m_chipselect = in_valid;
            m_address    = WR_ADDR;
            m_writedata  = in_data;
            if (in_valid) begin
               if (cnt == IN_LAST) begin
                  state_nxt = S_GAP;
                  cnt_nxt   = '0;
                  gap_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end

         S_GAP: begin
            if (gap_cnt == GAP_LAST) begin
`ifdef DIGIT_HOST_POLL_EN
               state_nxt = S_POLL;
`else
               state_nxt = S_READ;
`endif
            end else begin
               gap_nxt = gap_cnt + 1'b1;
            end
         end

`ifdef DIGIT_HOST_POLL_EN
         S_POLL: begin
            // Status data returns one cycle after each strobe. A new poll is
            // issued only as the previous one completes.
            if (poll_pend && m_readdata[0]) begin
               state_nxt = S_READ;
            end else begin
               poll_issue   = 1'b1;
               m_read       = 1'b1;
               m_chipselect = 1'b1;
               m_address    = ST_ADDR;
            end
         end
`endif

         S_READ: begin
            // Count the read in flight against the FIFO depth. A word is then
            // guaranteed a slot before its read is issued.
            if (rf_occ < RF_FULL) begin
               rd_issue     = 1'b1;
               m_read       = 1'b1;
               m_chipselect = 1'b1;
               m_address    = RD_ADDR;
               if (cnt == OUT_LAST) begin
                  state_nxt = S_DRAIN;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end

         S_DRAIN: begin
            if (rf_count == '0 && !rd_pend) begin
               done      = 1'b1;
               state_nxt = S_IDLE;
            end
         end

         default: state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_digit_host_master.sv
// -----------------------------------------------------------------------------
// tb_digit_host_master
//
// Directed bench for digit_host_master. The bench includes a small model of
// the slave. Its write pointer wraps at IN_WORDS and its read pointer wraps at
// OUT_WORDS. The read port returns the stored input words, so each job's
// results are the first OUT_WORDS inputs of that job. Status reads return 0
// five times and then 1.
//
// Cycle index k counts clock edges after the edge that accepts start. The
// first busy cycle is k=1.
// -----------------------------------------------------------------------------
module tb_digit_host_master;

   localparam int         IN_WORDS   = 26;
   localparam int         OUT_WORDS  = 11;
   localparam int         GAP_CYCLES = 4;
   localparam int         RF_DEPTH   = 4;
   localparam logic [2:0] WR_ADDR    = 3'h2;
   localparam logic [2:0] RD_ADDR    = 3'h3;
   localparam logic [2:0] ST_ADDR    = 3'h1;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        busy;
   logic        done;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        m_chipselect;
   logic [2:0]  m_address;
   logic        m_read;
   logic        m_write;
   logic [15:0] m_writedata;
   logic [15:0] m_readdata;

   always #5 clk = ~clk;

   digit_host_master #(
      .IN_WORDS  (IN_WORDS),
      .OUT_WORDS (OUT_WORDS),
      .WR_ADDR   (WR_ADDR),
      .RD_ADDR   (RD_ADDR),
      .ST_ADDR   (ST_ADDR),
      .GAP_CYCLES(GAP_CYCLES),
      .RF_DEPTH  (RF_DEPTH)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .busy        (busy),
      .done        (done),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .m_chipselect(m_chipselect),
      .m_address   (m_address),
      .m_read      (m_read),
      .m_write     (m_write),
      .m_writedata (m_writedata),
      .m_readdata  (m_readdata)
   );

   // ---------------- slave model ----------------
   logic [15:0] slv_mem [IN_WORDS];
   int          slv_wp;
   int          slv_rp;
   int          slv_st;
   logic [15:0] slv_rdata;

   always @(posedge clk) begin
      if (reset) begin
         slv_wp    <= 0;
         slv_rp    <= 0;
         slv_st    <= 0;
         slv_rdata <= 16'h0000;
      end else if (m_chipselect) begin
         if (m_write && m_address == WR_ADDR) begin
            slv_mem[slv_wp] <= m_writedata;
            slv_wp          <= (slv_wp == IN_WORDS - 1) ? 0 : slv_wp + 1;
         end
         if (m_read && m_address == RD_ADDR) begin
            slv_rdata <= slv_mem[slv_rp];
            slv_rp    <= (slv_rp == OUT_WORDS - 1) ? 0 : slv_rp + 1;
         end
         if (m_read && m_address == ST_ADDR) begin
            if (slv_st == 5) begin
               slv_rdata <= 16'h0001;
               slv_st    <= 0;
            end else begin
               slv_rdata <= 16'h0000;
               slv_st    <= slv_st + 1;
            end
         end
      end
   end

   assign m_readdata = slv_rdata;

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   // Per-job observations
   int          wr_n, wr_bad, wr_first_k, wr_last_k;
   int          rd_n, rd_bad, rd_first_k;
   int          st_n, st_last_k;
   int          res_n, done_k, strobe_bad, rd_at_release;
   logic [15:0] res_log [16];
   logic        got_done;

   // Runs one job. stall_at/stall_len drop in_valid for stall_len cycles once
   // stall_at words are accepted. out_ready stays low through cycle bp_len.
   // With abort_at >= 0, reset is pulsed while word abort_at is written.
   task automatic run_job(input logic [15:0] base, input int stall_at, input int stall_len,
                          input int bp_len, input int abort_at);
      int idx     = 0;
      int stalled = 0;
      wr_n = 0; wr_bad = 0; wr_first_k = -1; wr_last_k = -1;
      rd_n = 0; rd_bad = 0; rd_first_k = -1;
      st_n = 0; st_last_k = -1;
      res_n = 0; done_k = -1; strobe_bad = 0; rd_at_release = -1;
      got_done = 1'b0;

      @(negedge clk);
      start     = 1'b1;
      in_valid  = 1'b1;
      in_data   = base;
      out_ready = (bp_len == 0);
      @(posedge clk);
      for (int k = 1; k <= 600 && !got_done; k++) begin
         @(negedge clk);
         start    = 1'b0;
         in_valid = (idx < IN_WORDS) && !(idx == stall_at && stalled < stall_len);
         if (idx == stall_at && stalled < stall_len) stalled++;
         in_data   = base + 16'(idx);
         out_ready = (k > bp_len);
         #1;
         if ((m_read && m_write) || ((m_read || m_write) != m_chipselect)) strobe_bad++;
         if (m_write) begin
            if (m_address !== WR_ADDR || m_writedata !== base + 16'(wr_n)) wr_bad++;
            if (wr_first_k < 0) wr_first_k = k;
            wr_last_k = k;
            wr_n++;
         end
         if (m_read) begin
            if (m_address == RD_ADDR) begin
               if (rd_first_k < 0) rd_first_k = k;
               rd_n++;
            end else if (m_address == ST_ADDR) begin
               st_last_k = k;
               st_n++;
            end else begin
               rd_bad++;
            end
         end
         if (k == bp_len) rd_at_release = rd_n;
         if (out_valid && out_ready) begin
            if (res_n < 16) res_log[res_n] = out_data;
            res_n++;
         end
         if (done) begin
            got_done = 1'b1;
            done_k   = k;
         end
         if (abort_at >= 0 && idx == abort_at && m_write) begin
            reset = 1'b1;
            @(posedge clk);
            #1;
            check("outputs_after_mid_job_reset",
                  {busy, done, in_ready, out_valid, out_data, m_chipselect,
                   m_read, m_write, m_address, m_writedata}, 64'd0);
            reset = 1'b0;
            return;
         end
         if (in_valid && in_ready) idx++;
      end
      check("done_seen", got_done, 1'b1);
   endtask

   task automatic check_job(input logic [15:0] base);
      check("write_count", wr_n, IN_WORDS);
      check("write_addr_data_bad", wr_bad, 0);
      check("read_count", rd_n, OUT_WORDS);
      check("read_addr_bad", rd_bad, 0);
      check("strobe_bad", strobe_bad, 0);
      check("result_count", res_n, OUT_WORDS);
      for (int i = 0; i < OUT_WORDS; i++)
         check($sformatf("result_%0d", i), res_log[i], base + 16'(i));
`ifdef DIGIT_HOST_POLL_EN
      check("status_polls", st_n, 6);
      check("poll_to_first_read", rd_first_k - st_last_k, 2);
`else
      check("status_polls", st_n, 0);
`endif
   endtask

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      in_valid  = 1'b1;
      in_data   = 16'hFFFF;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("outputs_in_reset",
            {busy, done, in_ready, out_valid, out_data, m_chipselect,
             m_read, m_write, m_address, m_writedata}, 64'd0);
      @(negedge clk);
      reset = 1'b0;

      // Basic job: back-to-back input, consumer always ready
      run_job(16'h0100, -1, 0, 0, -1);
      check_job(16'h0100);
      check("write_span", wr_last_k - wr_first_k + 1, IN_WORDS);
`ifndef DIGIT_HOST_POLL_EN
      check("gap_idle_cycles", rd_first_k - wr_last_k - 1, GAP_CYCLES);
      check("done_latency", done_k - 1, IN_WORDS + GAP_CYCLES + OUT_WORDS + 2);
`endif
      @(negedge clk);
      #1;
      check("idle_after_done", {busy, done, m_chipselect}, 3'b000);

      // Input stall: in_valid low for 3 cycles after word 10
      run_job(16'h0200, 11, 3, 0, -1);
      check_job(16'h0200);
      check("stalled_write_span", wr_last_k - wr_first_k + 1, IN_WORDS + 3);

      // Backpressure: consumer stalled well into the read phase
      run_job(16'h0300, -1, 0, 50, -1);
      check_job(16'h0300);
      check("reads_before_release", rd_at_release, RF_DEPTH);

      // Back-to-back: start the cycle after done
      run_job(16'h0400, -1, 0, 0, -1);
      check_job(16'h0400);

      // Reset during write word 13, then a fresh job
      run_job(16'h0500, -1, 0, 0, 13);
      run_job(16'h0600, -1, 0, 0, -1);
      check_job(16'h0600);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/digit_host_master.md
# digit_host_master

Avalon-MM initiator that drives the digit-recognition testbench slave from the host side of the fabric. On `start` it streams IN_WORDS input words from a valid/ready source into the slave's auto-incrementing write port. It waits for the result, then issues OUT_WORDS reads from the auto-incrementing read port and forwards the returned words on a valid/ready result stream through a small skid FIFO. It sits between the host-side data mover and the accelerator's 16-bit register window.

## Interface
Parameters:
- IN_WORDS, 26, words written per job (slave write-pointer wrap)
- OUT_WORDS, 11, words read per job (slave read-pointer wrap)
- WR_ADDR, 3'h2, slave data-in address
- RD_ADDR, 3'h3, slave data-out address
- ST_ADDR, 3'h1, slave status address (polling only)
- GAP_CYCLES, 4, idle cycles between write and read phase (≥1)
- RF_DEPTH, 4, result FIFO depth (power of two, ≥2)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  begin one job; sampled only in IDLE
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after last result word leaves the FIFO
- in_valid  in  1  input word available
- in_ready  out  1  input word consumed this cycle
- in_data  in  16  input word
- out_valid  out  1  result word available
- out_ready  in  1  consumer accepts result word
- out_data  out  16  result word
- m_chipselect  out  1  Avalon chipselect
- m_address  out  3  Avalon word address
- m_read  out  1  read strobe
- m_write  out  1  write strobe
- m_writedata  out  16  write data
- m_readdata  in  16  read data

## Operation
- FSM: IDLE → WRITE → GAP → (POLL) → READ → DRAIN → IDLE.
- IDLE: all strobes low. `start` → WRITE, `busy`=1, write counter cleared.
- WRITE: `m_write`=`m_chipselect`=`in_ready`=`in_valid`; `m_address`=WR_ADDR; `m_writedata`=`in_data`. Counter increments per accepted word. When `in_valid`=0, no strobe is issued and the FSM stalls. After word IN_WORDS-1 → GAP.
- GAP: strobes low for GAP_CYCLES. Guarantees the slave pointer wrap cycle completes. Then → READ, or → POLL when polling is compiled in.
- READ: issue a read (`m_read`=`m_chipselect`=1, `m_address`=RD_ADDR) only when FIFO occupancy + outstanding < RF_DEPTH. Count issued reads. After read OUT_WORDS-1 is issued → DRAIN.
- Read data is captured into the FIFO exactly 1 cycle after each read strobe. Outstanding is at most 1.
- DRAIN: no strobes. When FIFO is empty and no read is outstanding → `done` pulse and IDLE.
- `start` while busy is ignored. `in_ready`=0 outside WRITE.
- Never assert `m_read` and `m_write` in the same cycle.
- Counters are $clog2(max(IN_WORDS,OUT_WORDS)+1) bits and compare against the parameter minus 1. No wrap inside a job.

## Timing
- Reset values: `busy`=0, `done`=0, `in_ready`=0, `out_valid`=0, `out_data`=0, `m_chipselect`=0, `m_read`=0, `m_write`=0, `m_address`=0, `m_writedata`=0.
- Reset mid-job: returns to IDLE, flushes the FIFO, clears counters and outstanding. No `done`.
- Avalon outputs are combinational from state and counters, with no waitrequest. One access per cycle.
- With back-to-back input and `out_ready`=1, a job takes IN_WORDS + GAP_CYCLES + OUT_WORDS + 2 cycles from start to done.
- FIFO full with `out_ready`=0: reads stall, so no word is ever dropped. Simultaneous push and pop on a full FIFO is allowed.
- `out_valid` rises the cycle after the first read data is captured.

## Configuration
- `DIGIT_HOST_POLL_EN` defined:
  - After GAP, POLL reads ST_ADDR every cycle.
  - Read data is checked 1 cycle later; bit 0 = 1 → READ.
  - Only one poll read is outstanding at a time.
- Not defined: POLL state absent; GAP goes directly to READ.

## Test plan
- Basic job: start; in_data 0x0100..0x0119 always valid; `out_ready`=1.
  - Required: 26 writes at address 2 with matching data, 4 idle cycles, 11 reads at address 3.
  - Out words equal the slave's mem[0..10]; `done` at cycle 26+4+11+2.
- Input stall: drop `in_valid` for 3 cycles after word 10 → `m_write` low for exactly those 3 cycles; write count still 26.
- Backpressure: `out_ready`=0 during READ → exactly RF_DEPTH=4 reads are issued, then stall. On release, all 11 words arrive in order with no loss.
- Back-to-back jobs: second start 1 cycle after `done` → slave pointers are aligned at 0; second job's results are correct.
- Reset at write word 13 → all outputs at reset values next cycle. A fresh job after reset is correct.
- With `DIGIT_HOST_POLL_EN`: status bit 0 returns 0 for 5 polls, then 1 → first read at address 3 occurs 2 cycles after the successful poll strobe.
